pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand and sum width in bits (>=1).
REQ-002 Parameter STAGE_WIDTH, default 2, bits resolved per pipeline stage; DATA_WIDTH SHALL be a multiple of STAGE_WIDTH, else elaboration error.
REQ-003 Port clk  in  1  sole clock, rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port a, b  in  DATA_WIDTH each  operands.
REQ-006 Port ci  in  1  carry-in.
REQ-007 Port sub  in  1  mode: 0 = a+b+ci, 1 = a+~b+ci.
REQ-008 Port in_vld / in_rd  in / out  1 / 1  input handshake.
REQ-009 Port s  out  DATA_WIDTH  sum.
REQ-010 Port co  out  1  carry-out of the MSB.
REQ-011 Port ovf  out  1  two's-complement overflow (carry into MSB xor carry out of MSB).
REQ-012 Port out_vld / out_rd  out / in  1 / 1  output handshake.

Function
REQ-013 STAGES = DATA_WIDTH/STAGE_WIDTH; stage k resolves bits [k*STAGE_WIDTH +: STAGE_WIDTH] by ripple carry from stage k-1's registered carry.
REQ-014 Transfer on a port occurs on a rising edge when vld and rd are both 1; vld SHALL NOT depend combinationally on rd.
REQ-015 Each stage holds: valid bit, carry, resolved sum bits, unresolved upper a and (mode-adjusted) b bits, and sub-bit no longer needed after inversion at entry.
REQ-016 Stage k advances when its successor is empty or advancing; in_rd = !vld[0] | advance[0]; last stage advances on out_rd.
REQ-017 Latency from input transfer to out_vld = STAGES cycles with out_rd held 1; throughput one result per cycle.
REQ-018 Bubbles SHALL collapse: an empty stage accepts data even if downstream is stalled.
REQ-019 While out_vld=1 and out_rd=0, s, co, ovf SHALL remain stable.
REQ-020 Results SHALL be exact modulo 2^DATA_WIDTH; co is the true carry out, including sub=1 (co=1 means no borrow when ci=1).
REQ-021 Transactions exit in arrival order; none dropped or duplicated under any out_rd pattern.
REQ-022 STAGE_WIDTH = DATA_WIDTH SHALL yield a single registered stage, latency 1.

Reset
REQ-023 While rst_n=0: all stage valid bits 0, out_vld=0, in_rd=0, s=0, co=0, ovf=0.
REQ-024 Assertion mid-operation SHALL discard all in-flight transactions immediately.
REQ-025 First cycle after deassertion: in_rd=1, out_vld=0.

Structure
REQ-026 Package pipe_adder_pkg SHALL hold the STAGES derivation function and the per-stage record type (vld, carry, sum bits, remaining operands).
REQ-027 One sub-module pipe_adder_stage (STAGE_WIDTH-bit ripple slice plus stage register and handshake), instantiated STAGES times via generate.
REQ-028 Combinational ripple slice SHALL use carry = a&b | a&c | b&c, sum = a^b^c per bit.

Verification (DATA_WIDTH=8, STAGE_WIDTH=2, STAGES=4)
REQ-029 a=0x0F, b=0x01, ci=0, sub=0, out_rd=1 -> after 4 cycles s=0x10, co=0, ovf=0, out_vld one cycle.
REQ-030 a=0xFF, b=0x01, ci=0 -> s=0x00, co=1, ovf=0; a=0x7F, b=0x01 -> s=0x80, co=0, ovf=1.
REQ-031 sub=1, ci=1: a=0x05, b=0x07 -> s=0xFE, co=0; a=0x07, b=0x05 -> s=0x02, co=1.
REQ-032 Back-to-back 4 transactions, out_rd=0 for 6 cycles -> in_rd falls after pipeline fills, outputs hold; release -> 4 results in order on 4 consecutive cycles.
REQ-033 Random out_rd (50%) with 1000 random operands -> every result matches reference model, order preserved.
REQ-034 rst_n pulsed low with 3 transactions in flight -> out_vld=0 asynchronously, no stale result emitted afterward.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-ripple adder.
// Stage records use a fixed maximum width so one type serves every DATA_WIDTH.
package pipe_adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  // Resolved sum bits accumulate in sum; a/b keep only the still-unresolved upper bits.
  typedef struct packed {
    logic                 vld;
    logic                 carry;
    logic                 ovf;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
  } stage_t;

  function automatic int unsigned calc_stages(input int unsigned data_width,
                                              input int unsigned stage_width);
    return data_width / stage_width;
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline slice: STAGE_WIDTH-bit ripple-carry adder feeding a registered
// stage record, with a ready chain that lets bubbles collapse.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STAGE_WIDTH = 2,
  parameter int unsigned IDX         = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t d,
  input  logic   down_rd,
  output logic   up_rd,
  output stage_t q
);

  localparam int unsigned BASE = IDX * STAGE_WIDTH;
  localparam bit          LAST = (BASE + STAGE_WIDTH == DATA_WIDTH);

  stage_t nxt;
  logic   c;
  logic   c_msb;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    nxt   = d;
    c     = d.carry;
    c_msb = 1'b0;
    for (int i = 0; i < int'(STAGE_WIDTH); i++) begin
      if (BASE + i == DATA_WIDTH - 1) c_msb = c;
      // NOTE: blocking assignments here model the ripple: the sum bit uses c before it is updated.
      nxt.sum[BASE+i] = d.a[BASE+i] ^ d.b[BASE+i] ^ c;
      c = (d.a[BASE+i] & d.b[BASE+i]) | (d.a[BASE+i] & c) | (d.b[BASE+i] & c);
      nxt.a[BASE+i] = 1'b0;
      nxt.b[BASE+i] = 1'b0;
    end
    nxt.carry = c;
    if (LAST) nxt.ovf = c_msb ^ c;
  end

  // The slot can take new data when empty or when its current content moves on.
  assign up_rd = !q.vld | down_rd;

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (up_rd) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor resolving STAGE_WIDTH bits per stage, with
// valid/ready handshakes on input and output.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STAGE_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  ci,
  input  logic                  sub,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  co,
  output logic                  ovf,
  output logic                  out_vld,
  input  logic                  out_rd
);

  localparam int unsigned STAGES = calc_stages(DATA_WIDTH, STAGE_WIDTH);

  if (STAGE_WIDTH == 0 || DATA_WIDTH == 0 || (DATA_WIDTH % STAGE_WIDTH) != 0 ||
      DATA_WIDTH > MAX_WIDTH) begin : g_bad_params
    $error("pipe_adder: DATA_WIDTH must be a nonzero multiple of STAGE_WIDTH and <= MAX_WIDTH");
  end

  stage_t        link [STAGES+1];
  logic [STAGES:0] rd;
  stage_t        entry;
  logic          unused_tail;

  // b is inverted once at entry; sub is not carried further down the pipe.
  always_comb begin
    entry                   = '0;
    entry.vld               = in_vld;
    entry.carry             = ci;
    entry.a[DATA_WIDTH-1:0] = a;
    entry.b[DATA_WIDTH-1:0] = sub ? ~b : b;
  end

  assign link[0]    = entry;
  assign rd[STAGES] = out_rd;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    pipe_adder_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .STAGE_WIDTH (STAGE_WIDTH),
      .IDX         (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (link[k]),
      .down_rd (rd[k+1]),
      .up_rd   (rd[k]),
      .q       (link[k+1])
    );
  end

  assign in_rd   = rst_n & rd[0];
  assign out_vld = link[STAGES].vld;
  assign s       = link[STAGES].sum[DATA_WIDTH-1:0];
  assign co      = link[STAGES].carry;
  assign ovf     = link[STAGES].ovf;

  // Operand bits are all consumed by the last stage; only the low sum bits leave.
  assign unused_tail = ^{link[STAGES].a, link[STAGES].b, link[STAGES].sum};

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (8-bit, 2 bits per stage): directed
// corner cases, backpressure, random traffic against an arithmetic model, reset flush.
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b, s;
  logic       ci, sub, in_vld, in_rd, co, ovf, out_vld, out_rd;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_adder #(.DATA_WIDTH(8), .STAGE_WIDTH(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .sub     (sub),
    .in_vld  (in_vld),
    .in_rd   (in_rd),
    .s       (s),
    .co      (co),
    .ovf     (ovf),
    .out_vld (out_vld),
    .out_rd  (out_rd)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, packed as {co, ovf, s}.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic m);
    logic [7:0] yy;
    int         total, ssum;
    logic [8:0] t9;
    logic       ov;
    yy    = m ? ~y : y;
    total = int'(x) + int'(yy) + int'(c);
    ssum  = int'($signed(x)) + int'($signed(yy)) + int'(c);
    ov    = (ssum > 127) || (ssum < -128);
    t9    = 9'(total);
    return {t9[8], ov, t9[7:0]};
  endfunction

  // Drive one cycle's inputs at the falling edge; report what transfers on the next rising edge.
  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, input logic is, input logic ir,
                      output logic fin, output logic fout);
    @(negedge clk);
    in_vld = iv; a = ia; b = ib; ci = ic; sub = is; out_rd = ir;
    #1;
    fin  = in_vld & in_rd;
    fout = out_vld & out_rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b1; a = 8'h5A; b = 8'hA5; ci = 1'b1; sub = 1'b0; out_rd = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({out_vld, in_rd, s, co, ovf} !== 12'h000)
      $display("FAIL reset_outputs: got out_vld=%b in_rd=%b s=%h co=%b ovf=%b, want all zero",
               out_vld, in_rd, s, co, ovf);
    else n_pass++;
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({in_rd, out_vld} !== 2'b10)
      $display("FAIL post_reset_handshake: got in_rd=%b out_vld=%b, want in_rd=1 out_vld=0",
               in_rd, out_vld);
    else n_pass++;
  endtask

  task automatic run_single(input logic [7:0] x, input logic [7:0] y, input logic c,
                            input logic m, input logic [7:0] es, input logic eco,
                            input logic eov, input string name);
    logic fin, fout;
    int   hits, lat;
    step(1'b1, x, y, c, m, 1'b1, fin, fout);
    n_checks++;
    if (fin !== 1'b1) $display("FAIL %s_accept: got in transfer=%b, want 1", name, fin);
    else n_pass++;
    hits = 0; lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, x, y, c, m, 1'b1, fin, fout);
      if (fout) begin
        hits++;
        if (hits == 1) begin
          lat = k;
          n_checks++;
          if ({s, co, ovf} !== {es, eco, eov})
            $display("FAIL %s_result: got s=%h co=%b ovf=%b, want s=%h co=%b ovf=%b",
                     name, s, co, ovf, es, eco, eov);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (lat != 4 || hits != 1)
      $display("FAIL %s_timing: got latency=%0d results=%0d, want latency=4 results=1",
               name, lat, hits);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_single(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
    run_single(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_single(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run_single(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
    run_single(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, "sub_07_05");
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs [4];
    logic [7:0] ys [4];
    logic       cs [4];
    logic       ms [4];
    logic [9:0] exp_v [4];
    logic       fin, fout;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 8'($urandom); ys[i] = 8'($urandom); cs[i] = 1'($urandom); ms[i] = 1'($urandom);
      exp_v[i] = model(xs[i], ys[i], cs[i], ms[i]);
      step(1'b1, xs[i], ys[i], cs[i], ms[i], 1'b0, fin, fout);
      n_checks++;
      if (fin !== 1'b1) $display("FAIL b2b_fill_%0d: got in transfer=%b, want 1", i, fin);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, fin, fout);
      n_checks++;
      if (fin !== 1'b0 || in_rd !== 1'b0 || out_vld !== 1'b1 || {co, ovf, s} !== exp_v[0])
        $display("FAIL b2b_stall_%0d: got in_rd=%b out_vld=%b {co,ovf,s}=%h, want 0 1 %h",
                 i, in_rd, out_vld, {co, ovf, s}, exp_v[0]);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, fin, fout);
      n_checks++;
      if (fout !== 1'b1 || {co, ovf, s} !== exp_v[i])
        $display("FAIL b2b_drain_%0d: got out transfer=%b {co,ovf,s}=%h, want 1 %h",
                 i, fout, {co, ovf, s}, exp_v[i]);
      else n_pass++;
    end
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, fin, fout);
    n_checks++;
    if (out_vld !== 1'b0) $display("FAIL b2b_empty: got out_vld=%b, want 0", out_vld);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [9:0] sb [$];
    logic [9:0] held_val, exp_v;
    logic       held, iv, ic, is, ir, fin, fout;
    logic [7:0] x, y;
    int         sent, cycles;
    sent = 0; cycles = 0; held = 1'b0; held_val = '0;
    while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
      iv = (sent < 1000) && ($urandom_range(0, 3) != 0);
      x = 8'($urandom); y = 8'($urandom); ic = 1'($urandom); is = 1'($urandom);
      ir = 1'($urandom);
      step(iv, x, y, ic, is, ir, fin, fout);
      cycles++;
      if (held) begin
        n_checks++;
        if (out_vld !== 1'b1 || {co, ovf, s} !== held_val)
          $display("FAIL rand_hold: got out_vld=%b {co,ovf,s}=%h, want 1 %h",
                   out_vld, {co, ovf, s}, held_val);
        else n_pass++;
      end
      if (fout) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL rand_spurious: got result {co,ovf,s}=%h, want none", {co, ovf, s});
        end else begin
          exp_v = sb.pop_front();
          if ({co, ovf, s} !== exp_v)
            $display("FAIL rand_result: got {co,ovf,s}=%h, want %h", {co, ovf, s}, exp_v);
          else n_pass++;
        end
      end
      if (fin) begin
        sb.push_back(model(x, y, ic, is));
        sent++;
      end
      held     = out_vld & ~out_rd;
      held_val = {co, ovf, s};
    end
    n_checks++;
    if (sent != 1000 || sb.size() != 0)
      $display("FAIL rand_complete: got sent=%0d pending=%0d, want 1000 and 0", sent, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_flush();
    logic fin, fout;
    int   stale;
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, fin, fout);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, fin, fout);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, fin, fout);
    n_checks++;
    if (out_vld !== 1'b1) $display("FAIL flush_pre: got out_vld=%b, want 1", out_vld);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_vld, in_rd, s, co, ovf} !== 12'h000)
      $display("FAIL flush_async: got out_vld=%b in_rd=%b s=%h co=%b ovf=%b, want all zero",
               out_vld, in_rd, s, co, ovf);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, fin, fout);
      if (out_vld) stale++;
    end
    n_checks++;
    if (stale != 0) $display("FAIL flush_stale: got %0d stale results, want 0", stale);
    else n_pass++;
    run_single(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "post_flush");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
